cpu_seq_ctrl: RTL and testbench
===============================

Name: cpu_seq_ctrl

Overview:
- Run/halt/single-step sequencer for the one-cycle CPU core (PC, ROM, instruction decoder).
- Holds the core in reset after power-up.
- Gates instruction commit through a single enable (CPU_EN) driven into PC, register file, ACC and data-memory write enables.
- Provides a PC breakpoint and a commit counter for debug and bring-up.

Parameters:
- AWIDTH, 8, PC/instruction address width (core WIDTH-IWIDTH).
- RST_HOLD, 4, cycles CPU_RST is held after RST deasserts (>=1).
- AUTO_RUN, 1, 1: leave BOOT into RUN; 0: leave BOOT into HALT.
- CNT_WIDTH, 16, width of commit counter.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- RUN_REQ  in  1  request free-running execution (level, sampled each edge).
- HALT_REQ  in  1  request halt.
- STEP_REQ  in  1  request execution of exactly one instruction from HALT.
- BP_EN  in  1  breakpoint enable.
- BP_ADDR  in  AWIDTH  breakpoint PC address.
- PC_IN  in  AWIDTH  current PC from core (PC_OUT).
- CPU_RST  out  1  reset to core PC/decoder, active-high.
- CPU_EN  out  1  commit enable for the current instruction.
- STATE  out  2  current state encoding.
- HALTED  out  1  STATE==HALT.
- BP_HIT  out  1  sticky: halted by breakpoint.
- LOOP_HIT  out  1  sticky self-loop halt (optional feature, else 0).
- COMMIT_CNT  out  CNT_WIDTH  instructions committed, saturating.

Behaviour:
- Clock is CLK; reset is RST, synchronous, active-high. RST in any state, including mid-STEP or mid-RUN, forces BOOT on the next edge.
- Reset values: STATE=BOOT, boot counter=RST_HOLD, CPU_RST=1, CPU_EN=0, HALTED=0, BP_HIT=0, LOOP_HIT=0, COMMIT_CNT=0, skip flag=0.
- States: BOOT=2'b00, RUN=2'b01, HALT=2'b10, STEP=2'b11.
- BOOT:
  - CPU_RST=1 and CPU_EN=0.
  - Counter decrements each cycle after RST low; at 0, next state is RUN (AUTO_RUN=1) or HALT.
  - CPU_RST is therefore high for exactly RST_HOLD cycles after RST falls.
  - All requests are ignored.
- CPU_RST is 0 in every state other than BOOT.
- CPU_EN is combinational: (RUN and not bp_match) or STEP. Requests affect CPU_EN only from the cycle after they are sampled.
- bp_match = BP_EN and PC_IN==BP_ADDR and not skip.
- RUN:
  - HALT_REQ: go to HALT. The instruction in the sampling cycle still commits.
  - bp_match: CPU_EN=0 in that cycle (breakpoint instruction not committed); go to HALT; set BP_HIT.
  - Otherwise stay in RUN.
- HALT:
  - CPU_EN=0.
  - Request priority HALT_REQ > STEP_REQ > RUN_REQ.
  - STEP_REQ: go to STEP.
  - RUN_REQ: go to RUN and set skip for the first RUN cycle, so resuming from a breakpoint address executes it.
  - Accepting STEP_REQ or RUN_REQ clears BP_HIT and LOOP_HIT.
- STEP:
  - Exactly one cycle with CPU_EN=1; breakpoint ignored; next state HALT unconditionally.
  - A held STEP_REQ yields one step per two cycles (STEP, HALT, STEP, ...).
- Skip flag is cleared after one RUN cycle.
- Simultaneous bp_match and HALT_REQ in RUN: HALT, CPU_EN=0, BP_HIT set.
- COMMIT_CNT:
  - Increments on each edge where CPU_EN=1.
  - Saturates at all-ones and never wraps.
  - Cleared only by RST.

Optional Feature:
- Macro CPU_SEQ_SELFLOOP_EN.
- Defined:
  - Registers last committed PC plus a valid bit.
  - In RUN, if CPU_EN=1 and PC_IN equals the last committed PC (a jump-to-self program end), go to HALT after this commit and set LOOP_HIT.
  - The valid bit is cleared on entering HALT and BOOT.
- Undefined: LOOP_HIT tied 0, no extra registers.

Decomposition:
- Package cpu_seq_pkg: state localparams/typedef (BOOT, RUN, HALT, STEP), STATE_W=2.
- One sub-module cpu_seq_bp: breakpoint comparator plus skip flag register. Ports CLK, RST, BP_EN, BP_ADDR, PC_IN, SET_SKIP, IN_RUN, output BP_MATCH.
- FSM, boot counter and commit counter stay in cpu_seq_ctrl.

Test Plan:
- Boot: RST high 3 cycles then low; RST_HOLD=4, AUTO_RUN=1 -> CPU_RST high exactly 4 cycles after RST falls, then STATE=RUN, CPU_EN=1, COMMIT_CNT increments every cycle.
- Halt/step: in RUN assert HALT_REQ one cycle -> the sampling-cycle instruction commits, then HALTED=1 and CPU_EN=0. Pulse STEP_REQ -> exactly one CPU_EN=1 cycle, COMMIT_CNT +1, back to HALT.
- Breakpoint: BP_EN=1, BP_ADDR=8'h05, PC_IN counting 0,1,2... -> CPU_EN=0 when PC_IN=5, STATE=HALT, BP_HIT=1. RUN_REQ -> first RUN cycle at PC 5 commits (skip), BP_HIT cleared.
- Priority: in HALT assert HALT_REQ, STEP_REQ and RUN_REQ together -> remains HALT, no commit. Then STEP_REQ and RUN_REQ together -> STEP.
- Reset mid-run and saturation: CNT_WIDTH=4, run 20 cycles -> COMMIT_CNT=4'hF held. Assert RST in RUN -> next edge STATE=BOOT, CPU_RST=1, COMMIT_CNT=0.
- Self-loop (with CPU_SEQ_SELFLOOP_EN): PC_IN held at 8'h0A in RUN -> after the second commit at 0A, STATE=HALT and LOOP_HIT=1. Without the macro, LOOP_HIT stays 0 and RUN continues.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared state encoding for the CPU run/halt/step sequencer.
package cpu_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10,
        STEP = 2'b11
    } state_e;

endpackage

// File: rtl/cpu_seq_bp.sv
// PC breakpoint comparator with a one-shot skip so a resume from the breakpoint
// address commits that instruction instead of re-trapping on it.
module cpu_seq_bp #(
    parameter int AWIDTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BP_EN,
    input  logic [AWIDTH-1:0] BP_ADDR,
    input  logic [AWIDTH-1:0] PC_IN,
    input  logic              SET_SKIP,
    input  logic              IN_RUN,
    output logic              BP_MATCH
);

    logic skip;

    always_ff @(posedge CLK) begin
        if (RST) begin
            skip <= 1'b0;
        end else if (SET_SKIP) begin
            skip <= 1'b1;
        end else if (IN_RUN) begin
            skip <= 1'b0;
        end
    end

    assign BP_MATCH = BP_EN && (PC_IN == BP_ADDR) && !skip;

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Run/halt/single-step sequencer gating instruction commit for the one-cycle core.
// Optional self-loop halt detection is enabled with the macro CPU_SEQ_SELFLOOP_EN.
//
// state | meaning
// BOOT  | core held in reset for RST_HOLD cycles, requests ignored
// RUN   | free-running, commits unless breakpoint matches
// HALT  | no commit, waiting for step or run request
// STEP  | one commit, then back to HALT
module cpu_seq_ctrl
    import cpu_seq_pkg::*;
#(
    parameter int AWIDTH    = 8,
    parameter int RST_HOLD  = 4,
    parameter int AUTO_RUN  = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RUN_REQ,
    input  logic                 HALT_REQ,
    input  logic                 STEP_REQ,
    input  logic                 BP_EN,
    input  logic [AWIDTH-1:0]    BP_ADDR,
    input  logic [AWIDTH-1:0]    PC_IN,
    output logic                 CPU_RST,
    output logic                 CPU_EN,
    output logic [STATE_W-1:0]   STATE,
    output logic                 HALTED,
    output logic                 BP_HIT,
    output logic                 LOOP_HIT,
    output logic [CNT_WIDTH-1:0] COMMIT_CNT
);

    localparam int BW = $clog2(RST_HOLD + 1);

    state_e               state, state_nxt;
    logic [BW-1:0]        boot_cnt;
    logic [CNT_WIDTH-1:0] commit_cnt;
    logic                 bp_match, loop_match;
    logic                 set_skip, set_bp, clr_hits;
    logic                 bp_hit;

    cpu_seq_bp #(.AWIDTH(AWIDTH)) u_bp (
        .CLK      (CLK),
        .RST      (RST),
        .BP_EN    (BP_EN),
        .BP_ADDR  (BP_ADDR),
        .PC_IN    (PC_IN),
        .SET_SKIP (set_skip),
        .IN_RUN   (state == RUN),
        .BP_MATCH (bp_match)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        set_skip  = 1'b0;
        set_bp    = 1'b0;
        clr_hits  = 1'b0;
        case (state)
            BOOT: begin
                // Leaving on count 1 keeps BOOT for exactly RST_HOLD cycles.
                if (boot_cnt <= BW'(1)) begin
                    state_nxt = (AUTO_RUN != 0) ? RUN : HALT;
                end
            end
            RUN: begin
                if (bp_match) begin
                    state_nxt = HALT;
                    set_bp    = 1'b1;
                end else if (HALT_REQ || loop_match) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                if (!HALT_REQ) begin
                    if (STEP_REQ) begin
                        state_nxt = STEP;
                        clr_hits  = 1'b1;
                    end else if (RUN_REQ) begin
                        state_nxt = RUN;
                        set_skip  = 1'b1;
                        clr_hits  = 1'b1;
                    end
                end
            end
            STEP:    state_nxt = HALT;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            boot_cnt <= BW'(RST_HOLD);
        end else if (state == BOOT && boot_cnt != '0) begin
            boot_cnt <= boot_cnt - BW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            commit_cnt <= '0;
        end else if (CPU_EN && commit_cnt != '1) begin
            commit_cnt <= commit_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bp_hit <= 1'b0;
        end else if (set_bp) begin
            bp_hit <= 1'b1;
        end else if (clr_hits) begin
            bp_hit <= 1'b0;
        end
    end

`ifdef CPU_SEQ_SELFLOOP_EN
    logic [AWIDTH-1:0] last_pc;
    logic              last_vld;
    logic              loop_hit;

    assign loop_match = last_vld && (PC_IN == last_pc) && CPU_EN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_vld <= 1'b0;
            last_pc  <= '0;
        end else if (state_nxt == HALT) begin
            last_vld <= 1'b0;
        end else if (CPU_EN) begin
            last_vld <= 1'b1;
            last_pc  <= PC_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            loop_hit <= 1'b0;
        end else if (state == RUN && loop_match) begin
            loop_hit <= 1'b1;
        end else if (clr_hits) begin
            loop_hit <= 1'b0;
        end
    end

    assign LOOP_HIT = loop_hit;
`else
    assign loop_match = 1'b0;
    assign LOOP_HIT   = 1'b0;
`endif

    assign CPU_EN     = (state == RUN && !bp_match) || (state == STEP);
    assign CPU_RST    = (state == BOOT);
    assign HALTED     = (state == HALT);
    assign STATE      = state;
    assign BP_HIT     = bp_hit;
    assign COMMIT_CNT = commit_cnt;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl; covers the self-loop halt when CPU_SEQ_SELFLOOP_EN is defined.
module tb_cpu_seq_ctrl;

    localparam logic [1:0] B = 2'b00, R = 2'b01, H = 2'b10, S = 2'b11;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RUN_REQ = 1'b0, HALT_REQ = 1'b0, STEP_REQ = 1'b0, BP_EN = 1'b0;
    logic [7:0] BP_ADDR = 8'h00, PC_IN = 8'h00;
    logic       CPU_RST, CPU_EN, HALTED, BP_HIT, LOOP_HIT;
    logic [1:0] STATE;
    logic [3:0] COMMIT_CNT;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic       rst, run, halt, step;
        logic [7:0] pc;
        logic [1:0] st;
        logic       en, crst, bph, lph;
        logic [3:0] cnt;
    } vec_t;

    vec_t sb[$];

    cpu_seq_ctrl #(.AWIDTH(8), .RST_HOLD(4), .AUTO_RUN(1), .CNT_WIDTH(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RUN_REQ    (RUN_REQ),
        .HALT_REQ   (HALT_REQ),
        .STEP_REQ   (STEP_REQ),
        .BP_EN      (BP_EN),
        .BP_ADDR    (BP_ADDR),
        .PC_IN      (PC_IN),
        .CPU_RST    (CPU_RST),
        .CPU_EN     (CPU_EN),
        .STATE      (STATE),
        .HALTED     (HALTED),
        .BP_HIT     (BP_HIT),
        .LOOP_HIT   (LOOP_HIT),
        .COMMIT_CNT (COMMIT_CNT)
    );

    always #5 CLK = ~CLK;

    // observed/expected layout: state, en, cpu_rst, halted, bp_hit, loop_hit, cnt
    function automatic logic [10:0] obs();
        return {STATE, CPU_EN, CPU_RST, HALTED, BP_HIT, LOOP_HIT, COMMIT_CNT};
    endfunction

    function automatic logic [10:0] want(input vec_t v);
        return {v.st, v.en, v.crst, (v.st == H), v.bph, v.lph, v.cnt};
    endfunction

    task automatic push(input logic r, input logic ru, input logic h, input logic s,
                        input logic [7:0] pc, input logic [1:0] st, input logic en,
                        input logic cr, input logic bh, input logic lh, input logic [3:0] cn);
        vec_t v;
        v.rst = r; v.run = ru; v.halt = h; v.step = s; v.pc = pc;
        v.st = st; v.en = en; v.crst = cr; v.bph = bh; v.lph = lh; v.cnt = cn;
        sb.push_back(v);
    endtask

    // Drive one cycle's inputs just after the edge and return at mid-cycle.
    task automatic apply(input vec_t v);
        @(posedge CLK);
        #1;
        RST = v.rst; RUN_REQ = v.run; HALT_REQ = v.halt; STEP_REQ = v.step; PC_IN = v.pc;
        #4;
    endtask

    task automatic reset_dut();
        vec_t v;
        v = '{rst: 1'b1, run: 1'b0, halt: 1'b0, step: 1'b0, pc: 8'h00,
              st: B, en: 1'b0, crst: 1'b1, bph: 1'b0, lph: 1'b0, cnt: 4'h0};
        apply(v);
        v.rst = 1'b0;
        repeat (4) apply(v);
    endtask

    task automatic test_boot();
        vec_t v;
        int   n = 0;
        v = '{rst: 1'b1, run: 1'b0, halt: 1'b0, step: 1'b0, pc: 8'h00,
              st: B, en: 1'b0, crst: 1'b1, bph: 1'b0, lph: 1'b0, cnt: 4'h0};
        apply(v);
        repeat (3) push(1, 0, 0, 0, 8'h00, B, 0, 1, 0, 0, 4'h0);
        push(0, 0, 0, 0, 8'h00, B, 0, 1, 0, 0, 4'h0);
        push(0, 1, 1, 1, 8'h00, B, 0, 1, 0, 0, 4'h0);
        push(0, 0, 0, 0, 8'h00, B, 0, 1, 0, 0, 4'h0);
        push(0, 0, 0, 0, 8'h00, B, 0, 1, 0, 0, 4'h0);
        push(0, 0, 0, 0, 8'h00, R, 1, 0, 0, 0, 4'h0);
        push(0, 0, 0, 0, 8'h01, R, 1, 0, 0, 0, 4'h1);
        push(0, 0, 0, 0, 8'h02, R, 1, 0, 0, 0, 4'h2);
        while (sb.size() > 0) begin
            v = sb.pop_front();
            apply(v);
            checks++;
            if (obs() !== want(v))
                $display("FAIL boot[%0d] st,en,rst,hlt,bp,lp,cnt got %b want %b", n, obs(), want(v));
            else
                passed++;
            n++;
        end
    endtask

    task automatic test_halt_step();
        vec_t v;
        int   n = 0;
        reset_dut();
        push(0, 0, 0, 0, 8'h00, R, 1, 0, 0, 0, 4'h0);
        push(0, 0, 1, 0, 8'h01, R, 1, 0, 0, 0, 4'h1);
        push(0, 0, 0, 0, 8'h02, H, 0, 0, 0, 0, 4'h2);
        push(0, 0, 0, 1, 8'h02, H, 0, 0, 0, 0, 4'h2);
        push(0, 0, 0, 0, 8'h02, S, 1, 0, 0, 0, 4'h2);
        push(0, 0, 0, 0, 8'h03, H, 0, 0, 0, 0, 4'h3);
        push(0, 0, 0, 0, 8'h03, H, 0, 0, 0, 0, 4'h3);
        push(0, 0, 0, 1, 8'h03, H, 0, 0, 0, 0, 4'h3);
        push(0, 0, 0, 1, 8'h03, S, 1, 0, 0, 0, 4'h3);
        push(0, 0, 0, 1, 8'h04, H, 0, 0, 0, 0, 4'h4);
        push(0, 0, 0, 0, 8'h04, S, 1, 0, 0, 0, 4'h4);
        push(0, 0, 0, 0, 8'h05, H, 0, 0, 0, 0, 4'h5);
        while (sb.size() > 0) begin
            v = sb.pop_front();
            apply(v);
            checks++;
            if (obs() !== want(v))
                $display("FAIL halt_step[%0d] st,en,rst,hlt,bp,lp,cnt got %b want %b", n, obs(), want(v));
            else
                passed++;
            n++;
        end
    endtask

    task automatic test_breakpoint();
        vec_t v;
        int   n = 0;
        reset_dut();
        BP_EN = 1'b1;
        BP_ADDR = 8'h05;
        for (int i = 0; i < 5; i++)
            push(0, 0, 0, 0, 8'(i), R, 1, 0, 0, 0, 4'(i));
        push(0, 0, 0, 0, 8'h05, R, 0, 0, 0, 0, 4'h5);
        push(0, 0, 0, 0, 8'h05, H, 0, 0, 1, 0, 4'h5);
        push(0, 1, 0, 0, 8'h05, H, 0, 0, 1, 0, 4'h5);
        push(0, 0, 0, 0, 8'h05, R, 1, 0, 0, 0, 4'h5);
        push(0, 0, 0, 0, 8'h05, R, 0, 0, 0, 0, 4'h6);
        push(0, 0, 0, 0, 8'h05, H, 0, 0, 1, 0, 4'h6);
        // priority: all three requests hold HALT, then STEP wins over RUN
        push(0, 1, 1, 1, 8'h05, H, 0, 0, 1, 0, 4'h6);
        push(0, 1, 0, 1, 8'h05, H, 0, 0, 1, 0, 4'h6);
        push(0, 0, 0, 0, 8'h05, S, 1, 0, 0, 0, 4'h6);
        push(0, 1, 0, 0, 8'h05, H, 0, 0, 0, 0, 4'h7);
        push(0, 0, 0, 0, 8'h05, R, 1, 0, 0, 0, 4'h7);
        push(0, 0, 1, 0, 8'h05, R, 0, 0, 0, 0, 4'h8);
        push(0, 0, 0, 0, 8'h05, H, 0, 0, 1, 0, 4'h8);
        while (sb.size() > 0) begin
            v = sb.pop_front();
            apply(v);
            checks++;
            if (obs() !== want(v))
                $display("FAIL breakpoint[%0d] st,en,rst,hlt,bp,lp,cnt got %b want %b", n, obs(), want(v));
            else
                passed++;
            n++;
        end
        BP_EN = 1'b0;
    endtask

    task automatic test_saturate_reset();
        vec_t v;
        int   n = 0;
        reset_dut();
        for (int i = 0; i < 20; i++)
            push(0, 0, 0, 0, 8'(i), R, 1, 0, 0, 0, (i < 15) ? 4'(i) : 4'hF);
        push(1, 0, 0, 0, 8'd20, R, 1, 0, 0, 0, 4'hF);
        repeat (4) push(0, 0, 0, 0, 8'd21, B, 0, 1, 0, 0, 4'h0);
        push(0, 0, 0, 0, 8'd22, R, 1, 0, 0, 0, 4'h0);
        while (sb.size() > 0) begin
            v = sb.pop_front();
            apply(v);
            checks++;
            if (obs() !== want(v))
                $display("FAIL saturate_reset[%0d] st,en,rst,hlt,bp,lp,cnt got %b want %b", n, obs(), want(v));
            else
                passed++;
            n++;
        end
    endtask

    task automatic test_selfloop();
        vec_t v;
        int   n = 0;
        reset_dut();
        push(0, 0, 0, 0, 8'h0A, R, 1, 0, 0, 0, 4'h0);
        push(0, 0, 0, 0, 8'h0A, R, 1, 0, 0, 0, 4'h1);
`ifdef CPU_SEQ_SELFLOOP_EN
        push(0, 0, 0, 0, 8'h0A, H, 0, 0, 0, 1, 4'h2);
        push(0, 0, 0, 1, 8'h0A, H, 0, 0, 0, 1, 4'h2);
        push(0, 0, 0, 0, 8'h0A, S, 1, 0, 0, 0, 4'h2);
        push(0, 0, 0, 0, 8'h0A, H, 0, 0, 0, 0, 4'h3);
`else
        for (int i = 2; i < 6; i++)
            push(0, 0, 0, 0, 8'h0A, R, 1, 0, 0, 0, 4'(i));
`endif
        while (sb.size() > 0) begin
            v = sb.pop_front();
            apply(v);
            checks++;
            if (obs() !== want(v))
                $display("FAIL selfloop[%0d] st,en,rst,hlt,bp,lp,cnt got %b want %b", n, obs(), want(v));
            else
                passed++;
            n++;
        end
    endtask

    initial begin
        test_boot();
        test_halt_step();
        test_breakpoint();
        test_saturate_reset();
        test_selfloop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
